process_sequencer: RTL and testbench
====================================

# process_sequencer

Frame-level sequencer for the sensor image-processing chain. It runs the four processing stages (write_image, coordinates, detection, read_image) in a fixed order. Each stage is started with an enable level and ends when the stage returns a done pulse. Stages can be skipped through a mask, frames can run one-shot or continuously, and a per-stage watchdog catches stalls. It sits between the Avalon/CPU control registers and the stage modules, and is the single owner of all stage enables.

## Interface
- TIMEOUT_CYCLES, 2**20: max cycles a stage may keep its enable high without done; must be ≥ 2.
- TIMEOUT_WIDTH, 21: watchdog counter width; must hold TIMEOUT_CYCLES-1.
- FRAME_WIDTH, 16: frame counter width.
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- in_start  in  1  start pulse; honoured only in IDLE.
- in_abort  in  1  abort; highest priority after reset.
- in_continuous  in  1  1 = restart automatically after each frame; sampled in DONE.
- in_stage_mask  in  4  bit i enables stage i (0 write_image, 1 coordinates, 2 detection, 3 read_image); latched on accepted start.
- in_write_image_done, in_coordinates_done, in_detection_done, in_read_image_done  in  1 each  stage done.
- out_write_image_en, out_coordinates_en, out_detection_en, out_read_image_en  out  1 each  stage enable; at most one high at a time.
- out_busy  out  1  high in every state except IDLE and ERROR.
- out_process_done  out  1  one-cycle pulse per completed frame.
- out_error  out  1  sticky watchdog error.
- out_timeout_stage  out  2  index of the stage that timed out.
- out_frame_count  out  FRAME_WIDTH  count of completed frames; wraps.

## Operation
- States: IDLE, RUN, GAP, DONE, ERROR. A registered 2-bit stage index cur selects the active stage.
- IDLE: on in_start with in_stage_mask ≠ 0, latch the mask, set cur = lowest set bit, go to RUN. in_start with mask = 0 is ignored.
- RUN: enable[cur] is high; the watchdog counts from 0.
  - done[cur] = 1: go to GAP if a higher mask bit is set, otherwise go to DONE.
  - Watchdog reaches TIMEOUT_CYCLES-1 with no done: go to ERROR and set out_timeout_stage = cur.
  - Done and timeout in the same cycle: done wins.
- GAP: one cycle with all enables low. cur advances to the next set mask bit, then the state returns to RUN with the watchdog cleared.
- DONE: one cycle. out_process_done = 1 and out_frame_count increments (wrapping modulo 2**FRAME_WIDTH).
  - in_continuous = 1: go to RUN at the first set bit of the latched mask. The mask is not re-sampled.
  - Otherwise: go to IDLE.
- ERROR: all enables low, out_error = 1. Leave only on in_abort or reset, both of which go to IDLE and clear out_error. out_timeout_stage holds until the next timeout.
- in_abort in any state: next state is IDLE, all enables low, no done pulse, frame count unchanged.
- A done input is ignored unless its own stage is in RUN. in_start outside IDLE is ignored.
- Reset values: all enables 0, out_busy 0, out_process_done 0, out_error 0, out_timeout_stage 0, out_frame_count 0, state IDLE. Reset asserted mid-frame drops the enables on the next edge.

## Timing
- All outputs are registered.
- Start sampled at edge t → first enable high from t+1.
- Done sampled at edge c with more stages left:
  - enable low at c+1 (GAP);
  - next enable high at c+2.
- Done sampled at edge c on the last stage:
  - enable low and out_process_done high at c+1;
  - new out_frame_count visible at c+2;
  - continuous mode: first enable high again at c+2.
- Watchdog: enable high at cycle e with no done → ERROR visible at e+TIMEOUT_CYCLES.
- Minimum frame with all four stages and immediate dones: 8 cycles from first enable to the done pulse.

## Structure
- Package process_sequencer_pkg holds:
  - state encoding constants;
  - stage index constants STAGE_WRITE = 0, STAGE_COORD = 1, STAGE_DETECT = 2, STAGE_READ = 3;
  - a next-set-bit function over the 4-bit mask.
- Sub-module stage_watchdog (TIMEOUT_CYCLES, TIMEOUT_WIDTH): inputs clear and run, output expired.

## Test plan
- Mask 4'b0110, start, dones 3 cycles after each enable → coordinates_en then detection_en with a one-cycle low gap; write/read enables never high; one done pulse; frame count 1.
- Mask 4'b1111, in_continuous = 1, immediate dones for 3 frames → done pulse every 8 cycles; frame count 3; enables always one-hot or zero.
- TIMEOUT_CYCLES = 16, mask 4'b0100, no detection done → out_error at enable+16; out_timeout_stage = 2; later in_start ignored; in_abort clears the error.
- Done and timeout coincident on the last cycle → frame completes; out_error stays 0.
- Abort during RUN, and reset_n low during GAP → all outputs return to reset values next edge; no done pulse.
- Start with mask 0; stray in_read_image_done while IDLE; FRAME_WIDTH = 2 run for 5 frames → no activity for the first two; count reads 1 after 5 frames (wrap).

Source files
------------

// File: rtl/process_sequencer_pkg.sv
// Shared types and helpers for the frame-level image-processing sequencer.
package process_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_GAP   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } seq_state_t;

  localparam logic [1:0] STAGE_WRITE  = 2'd0;
  localparam logic [1:0] STAGE_COORD  = 2'd1;
  localparam logic [1:0] STAGE_DETECT = 2'd2;
  localparam logic [1:0] STAGE_READ   = 2'd3;
  localparam int         NUM_STAGES   = 4;

  // Lowest set mask bit at or above position 'from'; 0 when none exists.
  function automatic logic [1:0] next_set_bit(input logic [3:0] mask, input logic [2:0] from);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (i >= int'(from) && mask[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic has_set_above(input logic [3:0] mask, input logic [1:0] cur);
    logic found;
    found = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i > int'(cur) && mask[i]) found = 1'b1;
    end
    return found;
  endfunction

endpackage

// File: rtl/process_sequencer_stage_watchdog.sv
// Per-stage stall watchdog: down-counter reloaded while idle, flags expiry at terminal count.
module stage_watchdog #(
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int TIMEOUT_WIDTH  = 21
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [TIMEOUT_WIDTH-1:0] LOAD_VALUE = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= LOAD_VALUE;
    end else if (clear) begin
      count <= LOAD_VALUE;
    end else if (run && count != '0) begin
      count <= count - TIMEOUT_WIDTH'(1);
    end
  end

  // Terminal count is reached after TIMEOUT_CYCLES-1 run cycles.
  assign expired = run && !clear && (count == '0);

endmodule

// File: rtl/process_sequencer.sv
// Frame sequencer: runs the four image-processing stages in order, owns all stage enables.
//   state | meaning
//   IDLE  | waiting for start with a non-zero mask
//   RUN   | enable[cur] high, watchdog counting
//   GAP   | one cycle all enables low, cur advances
//   DONE  | frame done pulse, count increments
//   ERROR | watchdog expired, sticky until abort/reset
module process_sequencer
  import process_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int TIMEOUT_WIDTH  = 21,
  parameter int FRAME_WIDTH    = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_start,
  input  logic                   in_abort,
  input  logic                   in_continuous,
  input  logic [3:0]             in_stage_mask,
  input  logic                   in_write_image_done,
  input  logic                   in_coordinates_done,
  input  logic                   in_detection_done,
  input  logic                   in_read_image_done,
  output logic                   out_write_image_en,
  output logic                   out_coordinates_en,
  output logic                   out_detection_en,
  output logic                   out_read_image_en,
  output logic                   out_busy,
  output logic                   out_process_done,
  output logic                   out_error,
  output logic [1:0]             out_timeout_stage,
  output logic [FRAME_WIDTH-1:0] out_frame_count
);

  seq_state_t state_q, state_d;
  logic [1:0] cur_q, cur_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] en_q, en_d;
  logic [3:0] done_vec;
  logic       expired;
  logic       tmo_load;

  assign done_vec = {in_read_image_done, in_detection_done,
                     in_coordinates_done, in_write_image_done};

  stage_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state_q != ST_RUN),
    .run     (state_q == ST_RUN),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    mask_d  = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (in_start && in_stage_mask != 4'b0000) begin
          mask_d  = in_stage_mask;
          cur_d   = next_set_bit(in_stage_mask, 3'd0);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A done on the expiry cycle still completes the stage.
        if (done_vec[cur_q]) begin
          state_d = has_set_above(mask_q, cur_q) ? ST_GAP : ST_DONE;
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_GAP: begin
        cur_d   = next_set_bit(mask_q, {1'b0, cur_q} + 3'd1);
        state_d = ST_RUN;
      end
      ST_DONE: begin
        if (in_continuous) begin
          cur_d   = next_set_bit(mask_q, 3'd0);
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
    if (in_abort) state_d = ST_IDLE;

    tmo_load = (state_q == ST_RUN) && (state_d == ST_ERROR);
    en_d = 4'b0000;
    if (state_d == ST_RUN) en_d[cur_d] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      cur_q             <= 2'd0;
      mask_q            <= 4'b0000;
      en_q              <= 4'b0000;
      out_busy          <= 1'b0;
      out_process_done  <= 1'b0;
      out_error         <= 1'b0;
      out_timeout_stage <= 2'd0;
      out_frame_count   <= '0;
    end else begin
      state_q          <= state_d;
      cur_q            <= cur_d;
      mask_q           <= mask_d;
      en_q             <= en_d;
      out_busy         <= (state_d != ST_IDLE) && (state_d != ST_ERROR);
      out_process_done <= (state_d == ST_DONE);
      out_error        <= (state_d == ST_ERROR);
      if (tmo_load) out_timeout_stage <= cur_q;
      if (state_q == ST_DONE && !in_abort) out_frame_count <= out_frame_count + FRAME_WIDTH'(1);
    end
  end

  assign out_write_image_en = en_q[STAGE_WRITE];
  assign out_coordinates_en = en_q[STAGE_COORD];
  assign out_detection_en   = en_q[STAGE_DETECT];
  assign out_read_image_en  = en_q[STAGE_READ];

endmodule

// File: tb/tb_process_sequencer.sv
// Directed bench for process_sequencer with a small stage-done responder.
module tb_process_sequencer;

  localparam int TC = 16;
  localparam int TW = 5;
  localparam int FW = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_start, in_abort, in_continuous;
  logic [3:0]    in_stage_mask;
  logic [3:0]    resp_done, force_done, resp_mask;
  logic          out_write_image_en, out_coordinates_en, out_detection_en, out_read_image_en;
  logic          out_busy, out_process_done, out_error;
  logic [1:0]    out_timeout_stage;
  logic [FW-1:0] out_frame_count;
  logic [3:0]    en;
  logic [10:0]   outv;

  int n_cmp = 0;
  int n_err = 0;
  int delay = 0;
  int pulses = 0;
  int onehot_viol = 0;
  int cnt [4];

  logic [3:0] t1_en   [11] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                               4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
  int         t2_pos  [3]  = '{7, 15, 23};

  assign en   = {out_read_image_en, out_detection_en, out_coordinates_en, out_write_image_en};
  assign outv = {en, out_busy, out_process_done, out_error, out_timeout_stage, out_frame_count};

  always #5 clock = ~clock;

  process_sequencer #(
    .TIMEOUT_CYCLES (TC),
    .TIMEOUT_WIDTH  (TW),
    .FRAME_WIDTH    (FW)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .in_start            (in_start),
    .in_abort            (in_abort),
    .in_continuous       (in_continuous),
    .in_stage_mask       (in_stage_mask),
    .in_write_image_done (resp_done[0] | force_done[0]),
    .in_coordinates_done (resp_done[1] | force_done[1]),
    .in_detection_done   (resp_done[2] | force_done[2]),
    .in_read_image_done  (resp_done[3] | force_done[3]),
    .out_write_image_en  (out_write_image_en),
    .out_coordinates_en  (out_coordinates_en),
    .out_detection_en    (out_detection_en),
    .out_read_image_en   (out_read_image_en),
    .out_busy            (out_busy),
    .out_process_done    (out_process_done),
    .out_error           (out_error),
    .out_timeout_stage   (out_timeout_stage),
    .out_frame_count     (out_frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    in_start      = 1'b0;
    in_abort      = 1'b0;
    in_continuous = 1'b0;
    in_stage_mask = 4'b0000;
    force_done    = 4'b0000;
    resp_mask     = 4'b1111;
    tick(2);
    pulses  = 0;
    reset_n = 1'b1;
    tick(1);
  endtask

  // Leaves the caller at the first negedge after start was sampled.
  task automatic start_frame(input logic [3:0] mask);
    in_stage_mask = mask;
    in_start      = 1'b1;
    tick(1);
    in_start      = 1'b0;
  endtask

  // Stage model: done asserted 'delay' cycles after its enable rises.
  initial begin
    resp_done = 4'b0000;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        if (en[i] && resp_mask[i]) begin
          resp_done[i] = (cnt[i] == delay);
          cnt[i]++;
        end else begin
          resp_done[i] = 1'b0;
          cnt[i] = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if ($countones(en) > 1) onehot_viol++;
      if (out_process_done === 1'b1) pulses++;
    end
  end

  initial begin
    int np;
    resp_mask = 4'b1111;
    force_done = 4'b0000;
    do_reset();
    chk("reset_outputs", 32'(outv), 32'd0);

    // Two middle stages, done three cycles after each enable.
    delay = 3;
    start_frame(4'b0110);
    for (int k = 0; k <= 10; k++) begin
      chk($sformatf("t1_en_%0d", k), 32'(en), 32'(t1_en[k]));
      chk($sformatf("t1_done_%0d", k), 32'(out_process_done), (k == 9) ? 32'd1 : 32'd0);
      if (k < 10) tick(1);
    end
    chk("t1_count", 32'(out_frame_count), 32'd1);
    chk("t1_busy", 32'(out_busy), 32'd0);
    tick(1);
    chk("t1_pulses", 32'(pulses), 32'd1);

    // All stages, immediate dones, continuous for three frames.
    do_reset();
    delay = 0;
    in_continuous = 1'b1;
    np = 0;
    start_frame(4'b1111);
    for (int k = 0; k <= 23; k++) begin
      if (k == 20) in_continuous = 1'b0;
      if (out_process_done === 1'b1) begin
        if (np < 3) chk("t2_pulse_pos", 32'(k), 32'(t2_pos[np]));
        np++;
      end
      tick(1);
    end
    chk("t2_pulse_cnt", 32'(np), 32'd3);
    chk("t2_count", 32'(out_frame_count), 32'd3);
    chk("t2_idle", 32'({en, out_busy}), 32'd0);

    // Watchdog on detection.
    do_reset();
    resp_mask = 4'b1011;
    start_frame(4'b0100);
    chk("t3_det_en", 32'(en), 32'b0100);
    tick(15);
    chk("t3_pre_err", 32'({out_error, en}), 32'b0_0100);
    tick(1);
    chk("t3_err", 32'(out_error), 32'd1);
    chk("t3_tmo_stage", 32'(out_timeout_stage), 32'd2);
    chk("t3_err_quiet", 32'({en, out_busy}), 32'd0);
    start_frame(4'b1111);
    tick(1);
    chk("t3_start_ignored", 32'({out_error, en, out_busy}), 32'b1_0000_0);
    in_abort = 1'b1;
    tick(1);
    in_abort = 1'b0;
    chk("t3_abort_clear", 32'({out_error, out_busy}), 32'd0);
    chk("t3_tmo_hold", 32'(out_timeout_stage), 32'd2);

    // Done on the expiry cycle completes the frame.
    do_reset();
    resp_mask = 4'b0111;
    start_frame(4'b1000);
    tick(15);
    force_done[3] = 1'b1;
    tick(1);
    force_done[3] = 1'b0;
    chk("t4_done", 32'({out_process_done, out_error}), 32'b10);
    tick(1);
    chk("t4_after", 32'({out_error, out_busy, out_frame_count}), 32'({1'b0, 1'b0, 2'd1}));

    // Abort during RUN.
    do_reset();
    delay = 3;
    start_frame(4'b1111);
    tick(1);
    in_abort = 1'b1;
    tick(1);
    in_abort = 1'b0;
    chk("t5_abort_outputs", 32'(outv), 32'd0);
    tick(4);
    chk("t5_abort_pulses", 32'(pulses), 32'd0);

    // Reset during GAP.
    do_reset();
    delay = 0;
    start_frame(4'b0011);
    tick(1);
    chk("t5_gap", 32'({en, out_busy}), 32'b0000_1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    chk("t5_reset_outputs", 32'(outv), 32'd0);
    tick(3);
    chk("t5_reset_quiet", 32'({pulses[3:0], out_busy}), 32'd0);

    // Empty mask, stray done, counter wrap.
    do_reset();
    start_frame(4'b0000);
    chk("t6_mask0", 32'({en, out_busy}), 32'd0);
    force_done[3] = 1'b1;
    tick(1);
    force_done[3] = 1'b0;
    tick(1);
    chk("t6_stray", 32'({en, out_busy, out_frame_count}), 32'd0);
    for (int f = 0; f < 5; f++) begin
      start_frame(4'b0001);
      tick(2);
      if (f == 3) chk("t6_wrap0", 32'(out_frame_count), 32'd0);
    end
    chk("t6_count", 32'(out_frame_count), 32'd1);
    chk("t6_pulses", 32'(pulses), 32'd5);

    chk("onehot", 32'(onehot_viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
